// File: rtl/canal_pkg.sv
`default_nettype none
// ============================================================================
// Module  : canal_pkg
// Purpose : Shared types and constants for the audio channel configuration
//           sequencer (FSM state encoding, configuration record, limits and
//           reset defaults).
// Revision: 1.0 - initial release
// ============================================================================
package canal_pkg;

  // Legal range limits for the channel settings
  localparam int NQUANT_MAX = 18;
  localparam int NQUANT_MIN = 1;
  localparam int NFREQ_MIN  = 1;

  // Reset-default live configuration
  localparam logic [3:0] SWITCHES_RST = 4'b0000;
  localparam logic [3:0] NFREQ_RST    = 4'd1;
  localparam logic [4:0] NQUANT_RST   = 5'd18;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MUTE_IN = 2'd1,
    APPLY   = 2'd2,
    SETTLE  = 2'd3
  } state_t;

  typedef struct packed {
    logic [3:0] switches;
    logic [3:0] nfreq;
    logic [4:0] nquant;
  } cfg_t;

  localparam cfg_t CFG_RST = '{switches: SWITCHES_RST,
                               nfreq:    NFREQ_RST,
                               nquant:   NQUANT_RST};

endpackage
`default_nettype wire

// File: rtl/canal_cfg_sanitize.sv
`default_nettype none
// ============================================================================
// Module  : canal_cfg_sanitize
// Purpose : Combinational clamp of a requested channel configuration into the
//           legal range: Nfreq 0 -> 1, Nquant 0 -> 1, Nquant > 18 -> 18,
//           switches passed through untouched.
// Ports   : cfg_i  - requested configuration
//           cfg_o  - sanitized configuration
//           err_o  - request needed clamping (only with CANAL_CFG_ERR_EN)
// Options : CANAL_CFG_ERR_EN - adds the err_o flag
// Revision: 1.0 - initial release
// ============================================================================
module canal_cfg_sanitize
  import canal_pkg::*;
(
  input  cfg_t cfg_i,
  output cfg_t cfg_o
`ifdef CANAL_CFG_ERR_EN
  ,
  output logic err_o
`endif
);

  logic nfreq_zero;
  logic nquant_zero;
  logic nquant_high;

  assign nfreq_zero  = (cfg_i.nfreq == 4'd0);
  assign nquant_zero = (cfg_i.nquant == 5'd0);
  assign nquant_high = (cfg_i.nquant > 5'(NQUANT_MAX));

  always_comb begin
    cfg_o = cfg_i;
    if (nfreq_zero) begin
      cfg_o.nfreq = 4'(NFREQ_MIN);
    end
    if (nquant_zero) begin
      cfg_o.nquant = 5'(NQUANT_MIN);
    end else if (nquant_high) begin
      cfg_o.nquant = 5'(NQUANT_MAX);
    end
  end

`ifdef CANAL_CFG_ERR_EN
  assign err_o = nfreq_zero | nquant_zero | nquant_high;
`endif

endmodule
`default_nettype wire

// File: rtl/canal_cfg_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : canal_cfg_ctrl
// Purpose : Configuration sequencer for one audio channel. New settings are
//           applied only at sample boundaries: mute for MUTE_SAMPLES strobes,
//           commit in one cycle, hold mute for SETTLE_SAMPLES strobes while
//           the filter history flushes, then release and acknowledge.
// Ports   : clock, reset        - master clock, synchronous active-high reset
//           data_en             - 1-cycle sample strobe (48 kHz)
//           cfg_load            - 1-cycle request to apply req_*
//           req_switches/Nfreq/Nquant - requested configuration
//           switches/Nfreq/Nquant     - live configuration to the channel
//           mute                - downstream forces data_out to 0
//           busy                - a sequence is in progress
//           cfg_ack             - 1-cycle pulse when a sequence completes
//           cfg_err             - sticky error flag (CANAL_CFG_ERR_EN only)
// Options : CANAL_CFG_ERR_EN - adds cfg_err (clamped request or overwritten
//           pending request; cleared by reset or a load accepted in IDLE)
// Revision: 1.0 - initial release
// ============================================================================
module canal_cfg_ctrl
  import canal_pkg::*;
#(
  parameter int MUTE_SAMPLES   = 8,
  parameter int SETTLE_SAMPLES = 64
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       data_en,
  input  logic       cfg_load,
  input  logic [3:0] req_switches,
  input  logic [3:0] req_Nfreq,
  input  logic [4:0] req_Nquant,
  output logic [3:0] switches,
  output logic [3:0] Nfreq,
  output logic [4:0] Nquant,
  output logic       mute,
  output logic       busy,
  output logic       cfg_ack
`ifdef CANAL_CFG_ERR_EN
  ,
  output logic       cfg_err
`endif
);

  localparam int CNT_MAX = (MUTE_SAMPLES > SETTLE_SAMPLES) ? MUTE_SAMPLES : SETTLE_SAMPLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_MUTE   = CNT_W'(MUTE_SAMPLES);
  localparam logic [CNT_W-1:0] CNT_SETTLE = CNT_W'(SETTLE_SAMPLES);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  cfg_t             live_q;
  cfg_t             shadow_q;
  cfg_t             pend_cfg_q;
  logic             pend_vld_q;
  logic             mute_q;
  logic             busy_q;
  logic             ack_q;

  cfg_t             req_cfg;
  cfg_t             san_cfg;
  logic             settle_done;
  logic             direct_restart;

  assign req_cfg = '{switches: req_switches, nfreq: req_Nfreq, nquant: req_Nquant};

`ifdef CANAL_CFG_ERR_EN
  logic san_err;
  logic err_q;

  canal_cfg_sanitize u_sanitize (
    .cfg_i (req_cfg),
    .cfg_o (san_cfg),
    .err_o (san_err)
  );
`else
  canal_cfg_sanitize u_sanitize (
    .cfg_i (req_cfg),
    .cfg_o (san_cfg)
  );
`endif

  // Settle ends on the strobe that brings the count to zero. The count can
  // already be zero on entry when SETTLE_SAMPLES=1 and a strobe hit APPLY.
  assign settle_done = (state_q == SETTLE) &&
                       ((cnt_q == '0) || (data_en && (cnt_q == CNT_ONE)));

  // A load landing exactly on a pending-free completion starts the next
  // sequence directly instead of being parked in the pending slot.
  assign direct_restart = settle_done && !pend_vld_q && cfg_load;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      live_q     <= CFG_RST;
      shadow_q   <= CFG_RST;
      pend_cfg_q <= CFG_RST;
      pend_vld_q <= 1'b0;
      mute_q     <= 1'b0;
      busy_q     <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      ack_q <= 1'b0;

      case (state_q)
        IDLE: begin
          // A strobe coincident with the load is deliberately not counted
          if (cfg_load) begin
            shadow_q <= san_cfg;
            cnt_q    <= CNT_MUTE;
            mute_q   <= 1'b1;
            busy_q   <= 1'b1;
            state_q  <= MUTE_IN;
          end
        end

        MUTE_IN: begin
          if (data_en) begin
            cnt_q <= cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
              state_q <= APPLY;
            end
          end
        end

        APPLY: begin
          live_q  <= shadow_q;
          // A strobe during the commit cycle already counts toward settling
          cnt_q   <= data_en ? (CNT_SETTLE - CNT_ONE) : CNT_SETTLE;
          state_q <= SETTLE;
        end

        SETTLE: begin
          if (settle_done) begin
            ack_q <= 1'b1;
            if (pend_vld_q) begin
              shadow_q   <= pend_cfg_q;
              pend_vld_q <= 1'b0;
              cnt_q      <= CNT_MUTE;
              state_q    <= MUTE_IN;
            end else if (cfg_load) begin
              shadow_q <= san_cfg;
              cnt_q    <= CNT_MUTE;
              state_q  <= MUTE_IN;
            end else begin
              cnt_q   <= '0;
              mute_q  <= 1'b0;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end
          end else if (data_en) begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase

      // Loads while busy park in the single pending slot, last one wins.
      // Placed after the FSM so a load in the consume cycle refills the slot.
      if (cfg_load && (state_q != IDLE) && !direct_restart) begin
        pend_cfg_q <= san_cfg;
        pend_vld_q <= 1'b1;
      end
    end
  end

`ifdef CANAL_CFG_ERR_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (cfg_load) begin
      if (state_q == IDLE) begin
        err_q <= san_err;
      end else begin
        // Overwrite: a valid pending entry that is not consumed this cycle
        err_q <= err_q | san_err | (pend_vld_q & ~settle_done);
      end
    end
  end

  assign cfg_err = err_q;
`endif

  assign switches = live_q.switches;
  assign Nfreq    = live_q.nfreq;
  assign Nquant   = live_q.nquant;
  assign mute     = mute_q;
  assign busy     = busy_q;
  assign cfg_ack  = ack_q;

endmodule
`default_nettype wire

// File: tb/tb_canal_cfg_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_canal_cfg_ctrl
// Purpose : Self-checking bench for canal_cfg_ctrl (MUTE_SAMPLES=8,
//           SETTLE_SAMPLES=64). Table of sanitize vectors plus directed
//           sequences for timing, pending requests and mid-sequence reset.
// Options : CANAL_CFG_ERR_EN - also checks cfg_err
// Revision: 1.0 - initial release
// ============================================================================
module tb_canal_cfg_ctrl;

  localparam int GAP = 4;   // idle cycles between sample strobes

  logic       clock;
  logic       reset;
  logic       data_en;
  logic       cfg_load;
  logic [3:0] req_switches;
  logic [3:0] req_Nfreq;
  logic [4:0] req_Nquant;
  logic [3:0] switches;
  logic [3:0] Nfreq;
  logic [4:0] Nquant;
  logic       mute;
  logic       busy;
  logic       cfg_ack;
`ifdef CANAL_CFG_ERR_EN
  logic       cfg_err;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  canal_cfg_ctrl #(
    .MUTE_SAMPLES   (8),
    .SETTLE_SAMPLES (64)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .data_en      (data_en),
    .cfg_load     (cfg_load),
    .req_switches (req_switches),
    .req_Nfreq    (req_Nfreq),
    .req_Nquant   (req_Nquant),
    .switches     (switches),
    .Nfreq        (Nfreq),
    .Nquant       (Nquant),
    .mute         (mute),
    .busy         (busy),
    .cfg_ack      (cfg_ack)
`ifdef CANAL_CFG_ERR_EN
    ,
    .cfg_err      (cfg_err)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Background monitors for the pending-request sequence
  logic mon_en   = 1'b0;
  logic mute_dip = 1'b0;
  logic seen_q8  = 1'b0;
  always @(negedge clock) begin
    if (mon_en) begin
      if (!mute)        mute_dip = 1'b1;
      if (Nquant == 5'd8) seen_q8 = 1'b1;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [3:0] sw;
    logic [3:0] nf;
    logic [4:0] nq;
    logic [3:0] esw;
    logic [3:0] enf;
    logic [4:0] enq;
    logic       eerr;
  } vec_t;

  vec_t vecs[7];

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // n strobes, each preceded by GAP idle cycles; returns just after the
  // edge that sampled the last strobe
  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) begin
      repeat (GAP) step();
      data_en = 1'b1;
      step();
      data_en = 1'b0;
    end
  endtask

  task automatic load(input logic [3:0] sw, input logic [3:0] nf, input logic [4:0] nq,
                      input logic with_en);
    req_switches = sw;
    req_Nfreq    = nf;
    req_Nquant   = nq;
    cfg_load     = 1'b1;
    data_en      = with_en;
    step();
    cfg_load = 1'b0;
    data_en  = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    data_en      = 1'b0;
    cfg_load     = 1'b0;
    req_switches = '0;
    req_Nfreq    = '0;
    req_Nquant   = '0;

    vecs[0] = '{sw: 4'hA, nf: 4'd0,  nq: 5'd25, esw: 4'hA, enf: 4'd1,  enq: 5'd18, eerr: 1'b1};
    vecs[1] = '{sw: 4'h3, nf: 4'd7,  nq: 5'd0,  esw: 4'h3, enf: 4'd7,  enq: 5'd1,  eerr: 1'b1};
    vecs[2] = '{sw: 4'hF, nf: 4'd15, nq: 5'd18, esw: 4'hF, enf: 4'd15, enq: 5'd18, eerr: 1'b0};
    vecs[3] = '{sw: 4'h0, nf: 4'd2,  nq: 5'd19, esw: 4'h0, enf: 4'd2,  enq: 5'd18, eerr: 1'b1};
    vecs[4] = '{sw: 4'h6, nf: 4'd0,  nq: 5'd0,  esw: 4'h6, enf: 4'd1,  enq: 5'd1,  eerr: 1'b1};
    vecs[5] = '{sw: 4'h9, nf: 4'd9,  nq: 5'd9,  esw: 4'h9, enf: 4'd9,  enq: 5'd9,  eerr: 1'b0};
    vecs[6] = '{sw: 4'h9, nf: 4'd9,  nq: 5'd9,  esw: 4'h9, enf: 4'd9,  enq: 5'd9,  eerr: 1'b0};

    // ---------------- reset state ----------------
    step();
    step();
    reset = 1'b0;
    repeat (100) step();
    check("rst_switches", 32'(switches), 32'd0);
    check("rst_Nfreq",    32'(Nfreq),    32'd1);
    check("rst_Nquant",   32'(Nquant),   32'd18);
    check("rst_mute",     32'(mute),     32'd0);
    check("rst_busy",     32'(busy),     32'd0);
    check("rst_ack",      32'(cfg_ack),  32'd0);
`ifdef CANAL_CFG_ERR_EN
    check("rst_err",      32'(cfg_err),  32'd0);
`endif

    // ---------------- exact timing, coincident strobe, strobe in APPLY ----------------
    load(4'b0101, 4'd4, 5'd12, 1'b1);
    check("t_mute_next", 32'(mute), 32'd1);
    check("t_busy_next", 32'(busy), 32'd1);
    pulses(7);
    check("t_old_after7", 32'(Nquant), 32'd18);
    pulses(1);
    check("t_old_at8", 32'(switches), 32'd0);
    // strobe during APPLY, counted as settle strobe #1
    data_en = 1'b1;
    step();
    data_en = 1'b0;
    check("t_sw_commit", 32'(switches), 32'd5);
    check("t_nf_commit", 32'(Nfreq),    32'd4);
    check("t_nq_commit", 32'(Nquant),   32'd12);
    pulses(62);
    check("t_mute_63", 32'(mute),    32'd1);
    check("t_ack_63",  32'(cfg_ack), 32'd0);
    pulses(1);
    check("t_ack_64",  32'(cfg_ack), 32'd1);
    check("t_mute_64", 32'(mute),    32'd0);
    check("t_busy_64", 32'(busy),    32'd0);
    step();
    check("t_ack_pulse", 32'(cfg_ack), 32'd0);

    // ---------------- sanitize table ----------------
    for (int i = 0; i < 7; i++) begin
      load(vecs[i].sw, vecs[i].nf, vecs[i].nq, 1'b0);
      check($sformatf("v%0d_busy", i), 32'(busy), 32'd1);
`ifdef CANAL_CFG_ERR_EN
      check($sformatf("v%0d_err", i), 32'(cfg_err), 32'(vecs[i].eerr));
`endif
      pulses(8);
      step();
      check($sformatf("v%0d_sw", i), 32'(switches), 32'(vecs[i].esw));
      check($sformatf("v%0d_nf", i), 32'(Nfreq),    32'(vecs[i].enf));
      check($sformatf("v%0d_nq", i), 32'(Nquant),   32'(vecs[i].enq));
      pulses(64);
      check($sformatf("v%0d_ack", i), 32'(cfg_ack), 32'd1);
      check($sformatf("v%0d_mute", i), 32'(mute),   32'd0);
      step();
    end

    // ---------------- two loads during SETTLE ----------------
    load(4'h1, 4'd2, 5'd10, 1'b0);
    mute_dip = 1'b0;
    seen_q8  = 1'b0;
    mon_en   = 1'b1;
    pulses(8);
    step();
    check("p_nq_first", 32'(Nquant), 32'd10);
    pulses(10);
    load(4'h1, 4'd2, 5'd8, 1'b0);
    pulses(5);
    load(4'h1, 4'd2, 5'd6, 1'b0);
    pulses(49);
    check("p_ack1",  32'(cfg_ack), 32'd1);
    check("p_busy1", 32'(busy),    32'd1);
    check("p_nq_hold", 32'(Nquant), 32'd10);
`ifdef CANAL_CFG_ERR_EN
    check("p_err_overwrite", 32'(cfg_err), 32'd1);
`endif
    pulses(7);
    check("p_nq_before", 32'(Nquant), 32'd10);
    pulses(1);
    step();
    check("p_nq_second", 32'(Nquant), 32'd6);
    pulses(64);
    check("p_ack2", 32'(cfg_ack), 32'd1);
    mon_en = 1'b0;
    check("p_mute_end", 32'(mute), 32'd0);
    check("p_no_dip", 32'(mute_dip), 32'd0);
    check("p_no_q8",  32'(seen_q8),  32'd0);
    step();

    // ---------------- reset in MUTE_IN, with a pending request ----------------
    load(4'hF, 4'd3, 5'd5, 1'b0);
    pulses(1);
    load(4'hE, 4'd5, 5'd7, 1'b0);
    pulses(1);
    repeat (GAP) step();
    data_en = 1'b1;
    reset   = 1'b1;
    step();
    data_en = 1'b0;
    reset   = 1'b0;
    check("r_switches", 32'(switches), 32'd0);
    check("r_Nfreq",    32'(Nfreq),    32'd1);
    check("r_Nquant",   32'(Nquant),   32'd18);
    check("r_mute",     32'(mute),     32'd0);
    check("r_busy",     32'(busy),     32'd0);
    pulses(80);
    check("r_no_commit_sw", 32'(switches), 32'd0);
    check("r_no_commit_nq", 32'(Nquant),   32'd18);
    check("r_still_idle",   32'(busy),     32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
